// File: rtl/cmn_skid_pkg.sv
// ----------------------------------------------------------------------------
// cmn_skid_pkg
// Shared types for the two-entry skid buffer. The state encoding equals the
// number of held messages, so the state register doubles as the occupancy
// output.
// ----------------------------------------------------------------------------
package cmn_skid_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

endpackage

// File: rtl/cmn_EnReg.sv
// ----------------------------------------------------------------------------
// cmn_EnReg
// Plain enable register, no reset. Loads d on a rising clk edge when en is high.
// Ports:
//   clk  in   clock
//   en   in   load enable
//   d    in   [p_nbits-1:0] next value
//   q    out  [p_nbits-1:0] registered value
// ----------------------------------------------------------------------------
module cmn_EnReg #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               en,
   input  logic [p_nbits-1:0] d,
   output logic [p_nbits-1:0] q
);

   always_ff @(posedge clk) begin
      if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/cmn_skid_buffer.sv
// ----------------------------------------------------------------------------
// cmn_skid_buffer
// Two-entry valid/ready skid buffer. Every output comes from a flop (enq_rdy
// is additionally forced low while reset is asserted), so producer and
// consumer are joined with no combinational path between them while still
// sustaining one transfer per cycle.
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous, active-high reset
//   enq_val    in   producer offers enq_msg
//   enq_rdy    out  buffer can accept
//   enq_msg    in   [p_nbits-1:0] incoming message
//   deq_val    out  deq_msg is valid
//   deq_rdy    in   consumer accepts deq_msg
//   deq_msg    out  [p_nbits-1:0] head message (main register)
//   occupancy  out  [1:0] number of held messages, 0..2
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | nothing held; deq_val low
// ONE   | head message in main; skid unused
// TWO   | head in main, next message in skid; enq_rdy low
// ----------------------------------------------------------------------------
module cmn_skid_buffer
   import cmn_skid_pkg::*;
#(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enq_val,
   output logic               enq_rdy,
   input  logic [p_nbits-1:0] enq_msg,
   output logic               deq_val,
   input  logic               deq_rdy,
   output logic [p_nbits-1:0] deq_msg,
   output logic [1:0]         occupancy
);

   skid_state_t        state_q;
   skid_state_t        state_d;
   logic               enq_fire;
   logic               deq_fire;
   logic               main_en;
   logic               main_sel_skid;
   logic               skid_en;
   logic [p_nbits-1:0] main_d;
   logic [p_nbits-1:0] skid_q;

   assign enq_rdy   = (state_q != TWO) && !reset;
   assign deq_val   = (state_q != EMPTY);
   assign occupancy = state_q;

   assign enq_fire  = enq_val && enq_rdy;
   // A consumer handshake on the reset edge must not move data.
   assign deq_fire  = deq_val && deq_rdy && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      main_en       = 1'b0;
      main_sel_skid = 1'b0;
      skid_en       = 1'b0;
      case (state_q)
         EMPTY: begin
            if (enq_fire) begin
               state_d = ONE;
               main_en = 1'b1;
            end
         end
         ONE: begin
            if (enq_fire && deq_fire) begin
               main_en = 1'b1;
            end else if (enq_fire) begin
               state_d = TWO;
               skid_en = 1'b1;
            end else if (deq_fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (deq_fire) begin
               state_d       = ONE;
               main_en       = 1'b1;
               main_sel_skid = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   assign main_d = main_sel_skid ? skid_q : enq_msg;

   cmn_EnReg #(.p_nbits(p_nbits)) u_main (
      .clk (clk),
      .en  (main_en),
      .d   (main_d),
      .q   (deq_msg)
   );

   cmn_EnReg #(.p_nbits(p_nbits)) u_skid (
      .clk (clk),
      .en  (skid_en),
      .d   (enq_msg),
      .q   (skid_q)
   );

endmodule

// File: tb/tb_cmn_skid_buffer.sv
module tb_cmn_skid_buffer;

   localparam int p_nbits = 32;

   logic               clk;
   logic               reset;
   logic               enq_val;
   logic               enq_rdy;
   logic [p_nbits-1:0] enq_msg;
   logic               deq_val;
   logic               deq_rdy;
   logic [p_nbits-1:0] deq_msg;
   logic [1:0]         occupancy;

   cmn_skid_buffer #(.p_nbits(p_nbits)) dut (
      .clk       (clk),
      .reset     (reset),
      .enq_val   (enq_val),
      .enq_rdy   (enq_rdy),
      .enq_msg   (enq_msg),
      .deq_val   (deq_val),
      .deq_rdy   (deq_rdy),
      .deq_msg   (deq_msg),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a FIFO of capacity two held as a queue.
   logic [p_nbits-1:0] mq[$];
   bit                 model_ok;
   int                 n_enq;
   int                 n_deq;
   int                 n_pass;
   int                 n_chk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model with the pre-edge inputs, then compare
   // every DUT output against the model at the falling edge.
   task automatic tick();
      bit ef;
      bit df;
      ef = !reset && enq_val && (mq.size() < 2);
      df = !reset && deq_rdy && (mq.size() > 0);
      @(posedge clk);
      if (reset) begin
         mq.delete();
         model_ok = 1'b1;
      end else begin
         if (df) begin
            void'(mq.pop_front());
            n_deq++;
         end
         if (ef) begin
            mq.push_back(enq_msg);
            n_enq++;
         end
      end
      @(negedge clk);
      if (model_ok) begin
         check("enq_rdy", {31'd0, enq_rdy}, {31'd0, (!reset && mq.size() < 2)});
         check("deq_val", {31'd0, deq_val}, {31'd0, (mq.size() > 0)});
         check("occupancy", {30'd0, occupancy}, mq.size());
         if (mq.size() > 0) begin
            check("deq_msg", deq_msg, mq[0]);
         end
      end
   endtask

   initial begin
      int start_enq;
      int guard;
      int prev_enq;
      int vld_cnt;
      logic [p_nbits-1:0] next_msg;

      model_ok = 1'b0;
      n_enq    = 0;
      n_deq    = 0;
      n_pass   = 0;
      n_chk    = 0;
      reset    = 1'b1;
      enq_val  = 1'b0;
      deq_rdy  = 1'b0;
      enq_msg  = '0;

      // Reset and idle
      tick();
      tick();
      check("rst_occ", {30'd0, occupancy}, 32'd0);
      check("rst_enq_rdy", {31'd0, enq_rdy}, 32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
      check("idle_deq_val", {31'd0, deq_val}, 32'd0);
      tick();
      tick();

      // Streaming 0x01..0x08 with deq_rdy held high
      deq_rdy = 1'b1;
      enq_val = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         enq_msg = p_nbits'(i);
         tick();
         check("stream_msg", deq_msg, i);
         check("stream_occ", {30'd0, occupancy}, 32'd1);
         check("stream_rdy", {31'd0, enq_rdy}, 32'd1);
      end
      enq_val = 1'b0;
      tick();
      check("stream_drained", {31'd0, deq_val}, 32'd0);

      // Fill to TWO, hold 0xC against backpressure, then drain
      deq_rdy = 1'b0;
      enq_val = 1'b1;
      enq_msg = 32'hA;
      tick();
      check("fill_occ1", {30'd0, occupancy}, 32'd1);
      enq_msg = 32'hB;
      tick();
      check("fill_occ2", {30'd0, occupancy}, 32'd2);
      check("fill_rdy_low", {31'd0, enq_rdy}, 32'd0);
      enq_msg = 32'hC;
      tick();
      tick();
      check("hold_head", deq_msg, 32'hA);
      check("hold_occ", {30'd0, occupancy}, 32'd2);
      deq_rdy = 1'b1;
      tick();
      check("after_a_head", deq_msg, 32'hB);
      check("after_a_rdy", {31'd0, enq_rdy}, 32'd1);
      check("after_a_occ", {30'd0, occupancy}, 32'd1);
      tick();
      check("after_b_head", deq_msg, 32'hC);
      enq_val = 1'b0;
      tick();
      check("after_c_empty", {31'd0, deq_val}, 32'd0);

      // Random valid/ready over 1000 messages
      start_enq = n_enq;
      next_msg  = 32'h1000;
      guard     = 0;
      while ((n_enq - start_enq) < 1000 && guard < 20000) begin
         enq_val  = 1'($urandom_range(0, 1));
         deq_rdy  = 1'($urandom_range(0, 1));
         enq_msg  = next_msg;
         prev_enq = n_enq;
         tick();
         if (n_enq != prev_enq) next_msg = next_msg + 1;
         guard++;
      end
      check("rand_enq_count", n_enq - start_enq, 32'd1000);

      // Drain, then sustained throughput with no bubbles
      enq_val = 1'b0;
      deq_rdy = 1'b1;
      tick();
      tick();
      tick();
      check("drain_empty", {30'd0, occupancy}, 32'd0);
      enq_val = 1'b1;
      vld_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         enq_msg = 32'h5000 + 32'(i);
         tick();
         if (deq_val) vld_cnt++;
      end
      check("tput_no_bubbles", vld_cnt, 32'd20);
      check("tput_last_head", deq_msg, 32'h5013);
      enq_val = 1'b0;
      tick();

      // Reset while holding two messages
      deq_rdy = 1'b0;
      enq_val = 1'b1;
      enq_msg = 32'h11;
      tick();
      enq_msg = 32'h22;
      tick();
      check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
      reset   = 1'b1;
      enq_val = 1'b0;
      deq_rdy = 1'b1;
      tick();
      check("midrst_deq_val", {31'd0, deq_val}, 32'd0);
      check("midrst_occ", {30'd0, occupancy}, 32'd0);
      reset = 1'b0;
      tick();
      check("midrst_release_rdy", {31'd0, enq_rdy}, 32'd1);
      enq_val = 1'b1;
      enq_msg = 32'h33;
      tick();
      check("midrst_first_msg", deq_msg, 32'h33);
      check("midrst_first_val", {31'd0, deq_val}, 32'd1);
      enq_val = 1'b0;
      tick();
      check("final_empty", {30'd0, occupancy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cmn_skid_buffer.md
# cmn_skid_buffer

Two-entry valid/ready skid buffer that registers every output of a latency-insensitive stream, so a producer and consumer can be joined with no combinational path between them. Sits between pipeline stages in common datapath components (for example, between the iterative multiplier's request/response interfaces and their neighbours) to break long `rdy` and `val` timing paths while sustaining one transfer per cycle.

## Interface
- `p_nbits`, default 32: message width in bits.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `enq_val`  in  1  producer offers `enq_msg`.
- `enq_rdy`  out  1  buffer can accept; driven only from state flops.
- `enq_msg`  in  `p_nbits`  incoming message.
- `deq_val`  out  1  `deq_msg` is valid; driven only from state flops.
- `deq_rdy`  in  1  consumer accepts `deq_msg`.
- `deq_msg`  out  `p_nbits`  head message; driven directly from the main data register.
- `occupancy`  out  2  number of held messages, 0..2.

## Operation
- Transfers: enq fires when `enq_val && enq_rdy`; deq fires when `deq_val && deq_rdy`.
- Storage: `main` register (head, drives `deq_msg`) and `skid` register (overflow entry). Neither data register is reset.
- FSM states: EMPTY (occupancy 0), ONE (1), TWO (2).
- Outputs by state: `deq_val` = (state != EMPTY); `enq_rdy` = (state != TWO) && !reset; `occupancy` = state encoding.
- EMPTY: enq fires -> ONE, `main` <= `enq_msg`. Deq cannot fire.
- ONE, enq and deq both fire -> stays ONE, `main` <= `enq_msg`.
- ONE, enq only -> TWO, `skid` <= `enq_msg`; `main` unchanged.
- ONE, deq only -> EMPTY.
- ONE, neither fires -> hold.
- TWO: enq cannot fire. Deq fires -> ONE, `main` <= `skid`. Otherwise hold.
- Ordering is strict FIFO; no message is dropped or duplicated.
- `deq_msg` is undefined while `deq_val` = 0, and the bench must not check it then.
- Inputs sampled while `reset` = 1 are ignored.

## Timing
- Reset: state EMPTY at the first posedge with `reset` = 1. While reset is high, `enq_rdy` = 0, `deq_val` = 0 and `occupancy` = 0. The first cycle after reset is released shows `enq_rdy` = 1.
- Reset mid-operation: all held messages are discarded; no deq fires on the reset edge.
- Latency: a message enqueued at edge N is visible on `deq_msg` with `deq_val` = 1 in the cycle after edge N. This is 1 cycle, with no bypass.
- Throughput: 1 message per cycle sustained whenever `deq_rdy` = 1.
- `enq_rdy` falls in the cycle after the second entry is written. It rises in the cycle after a deq from TWO.
- No combinational path exists from any input to `enq_rdy`, `deq_val`, `deq_msg` or `occupancy`.

## Structure
- Shared package `cmn_skid_pkg`: `typedef enum logic [1:0] {EMPTY=2'd0, ONE=2'd1, TWO=2'd2} skid_state_t`. The encoding equals occupancy, so `occupancy` is the state register itself.
- State register: a reset register with reset value EMPTY.
- Sub-module: instantiate the team's `cmn_EnReg` twice (`p_nbits`), once for `main` and once for `skid`.
- `main` is written from a 2:1 mux selecting `enq_msg` or `skid`, with a single enable. `skid` takes `enq_msg` on the ONE->TWO write.
- Target RTL size: about 120–160 lines including the package.

## Test plan
- Reset, then idle with `enq_val` = 0 -> `enq_rdy` = 1, `deq_val` = 0, `occupancy` = 0 on every cycle.
- Stream 0x01..0x08 with `deq_rdy` held at 1 -> `deq_msg` shows 0x01..0x08 in order, one per cycle, each one cycle after its enq; `enq_rdy` stays 1 and occupancy stays 1.
- Enq 0xA, then 0xB with `deq_rdy` = 0 -> occupancy goes 1 then 2, and `enq_rdy` = 0 in the following cycle. Raise `deq_rdy` -> 0xA is dequeued then 0xB, and `enq_rdy` returns to 1 the cycle after the 0xA deq.
- In TWO, hold `enq_val` = 1 with msg 0xC -> 0xC is not accepted until `enq_rdy` = 1. The final deq order is 0xA, 0xB, 0xC.
- Random `enq_val`/`deq_rdy` at 50% over 1000 messages (p_nbits = 32) -> the scoreboard sees exact FIFO order, occupancy never exceeds 2, and the throughput phase with `deq_rdy` = 1 shows zero bubbles.
- Reset asserted while in TWO holding 0x11, 0x22 -> next cycle `deq_val` = 0 and occupancy = 0. After release, enq 0x33 is the first message dequeued.
